// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// op classes, ALU control codes, condition codes and the condition evaluator.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] OP_DP    = 2'b00;
   localparam logic [1:0] OP_MEM   = 2'b01;
   localparam logic [1:0] OP_BR    = 2'b10;
   localparam logic [1:0] OP_UNDEF = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [3:0] LR_ADDR = 4'd14;

   // flags are packed NZCV, MSB first
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: return z;
         COND_NE: return ~z;
         COND_CS: return c;
         COND_CC: return ~c;
         COND_MI: return n;
         COND_PL: return ~n;
         COND_VS: return v;
         COND_VC: return ~v;
         COND_HI: return c & ~z;
         COND_LS: return ~c | z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return ~z & (n == v);
         COND_LE: return z | (n != v);
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cond_logic.sv
// Stored NZCV flags, condition evaluation against them, and the flag-update
// path. CondEx always sees the flags as they were before this cycle's update.
module cond_logic
   import ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] cond_i,
   input  logic [3:0] alu_flags_i,
   input  logic       flag_w_i,
   input  logic       cv_w_i,
   output logic       cond_ex_o
);

   logic [3:0] flags_q, flags_d;

   assign cond_ex_o = cond_eval(cond_i, flags_q);

   always_comb begin
      flags_d = flags_q;
      if (flag_w_i && cond_ex_o) begin
         flags_d[3:2] = alu_flags_i[3:2];
         if (cv_w_i) flags_d[1:0] = alu_flags_i[1:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) flags_q <= 4'b0000;
      else       flags_q <= flags_d;
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle ARM-subset datapath.
// Optional macro CTRL_BL_EN: BL writes the return address to R14 in BRANCH.
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4
// DECODE | read registers, precompute PC+8
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write load data to Rd
// MEMWR  | write data memory
// EXECR  | ALU with register operand
// EXECI  | ALU with immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | PC <= branch target
module multicycle_controller
   import ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl,
   output logic [3:0]  WA3,
   output logic [3:0]  State
);

   state_t     state_q, state_d;
   logic [1:0] op;
   logic [5:0] funct;
   logic       cond_ex, ir_w, pc_fetch, reg_w, mem_w, br, bl_w, exec_st;
   logic       unused_instr;

   assign op           = Instr[27:26];
   assign funct        = Instr[25:20];
   assign unused_instr = ^{Instr[19:16], Instr[11:0]};
   assign State        = state_q;
   assign exec_st      = (state_q == S_EXECR) || (state_q == S_EXECI);

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ir_w      = 1'b0;
      pc_fetch  = 1'b0;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      br        = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            ir_w = 1'b1; pc_fetch = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWB:  begin ResultSrc = 2'b01; reg_w = 1'b1; end
         S_MEMWR:  begin AdrSrc = 1'b1; mem_w = 1'b1; end
         S_EXECI:  ALUSrcB = 2'b01;
         S_ALUWB:  reg_w = 1'b1;
         S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; br = 1'b1; end
         default:  ;
      endcase
   end

   always_comb begin
      ALUControl = ALU_ADD;
      if (exec_st) begin
         case (funct[4:1])
            CMD_SUB: ALUControl = ALU_SUB;
            CMD_AND: ALUControl = ALU_AND;
            CMD_ORR: ALUControl = ALU_ORR;
            default: ALUControl = ALU_ADD;
         endcase
      end
   end

   assign ImmSrc = op;
   assign RegSrc = {op == OP_MEM, op == OP_BR};

   cond_logic u_cond (
      .CLK         (CLK),
      .RESET       (RESET),
      .cond_i      (Instr[31:28]),
      .alu_flags_i (ALUFlags),
      .flag_w_i    (exec_st & funct[0]),
      .cv_w_i      ((funct[4:1] == CMD_ADD) || (funct[4:1] == CMD_SUB)),
      .cond_ex_o   (cond_ex)
   );

`ifdef CTRL_BL_EN
   assign bl_w = (state_q == S_BRANCH) & Instr[24] & cond_ex;
`else
   assign bl_w = 1'b0;
`endif

   // an instruction caught by RESET must not leave any architectural write behind
   assign PCWrite  = ~RESET & (pc_fetch | (br & cond_ex));
   assign IRWrite  = ~RESET & ir_w;
   assign RegWrite = ~RESET & ((reg_w & cond_ex) | bl_w);
   assign MemWrite = ~RESET & mem_w & cond_ex;
   assign WA3      = bl_w ? LR_ADDR : Instr[15:12];

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output
// vectors are queued with each instruction and compared as the FSM steps.
module tb_multicycle_controller;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
   logic [3:0]  WA3, State;

   multicycle_controller dut (
      .CLK(CLK), .RESET(RESET), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .WA3(WA3), .State(State)
   );

   always #5 CLK = ~CLK;

   // {State, PCWrite, IRWrite, RegWrite, MemWrite, WA3, ResultSrc, ALUControl,
   //  AdrSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc}
   logic [23:0] obs;
   assign obs = {State, PCWrite, IRWrite, RegWrite, MemWrite, WA3, ResultSrc,
                 ALUControl, AdrSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc};

   typedef struct {
      string       nm;
      logic [23:0] v;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [23:0] ev(logic [3:0] st, logic [3:0] we, logic [3:0] wa,
                                      logic [1:0] rs, logic [1:0] ac, logic adr, logic sa,
                                      logic [1:0] sb, logic [3:0] src);
      return {st, we, wa, rs, ac, adr, sa, sb, src};
   endfunction

   function automatic void push(string nm, logic [23:0] v);
      exp_t x;
      x.nm = nm;
      x.v  = v;
      sb_q.push_back(x);
   endfunction

   function automatic void push_fd(logic [3:0] wa, logic [3:0] src);
      push("fetch",  ev(4'd0, 4'b1100, wa, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, src));
      push("decode", ev(4'd1, 4'b0000, wa, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, src));
   endfunction

   task automatic test_reset;
      RESET = 1'b1; Instr = 32'h0; ALUFlags = 4'h0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      n_checks++;
      if (obs !== ev(4'd0, 4'b0000, 4'd0, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 4'b0000)) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs,
                  ev(4'd0, 4'b0000, 4'd0, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 4'b0000));
      end
      RESET = 1'b0;
   endtask

   task automatic run_instr(logic [31:0] ins, logic [3:0] flg);
      Instr = ins; ALUFlags = flg;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         #1;
         n_checks++;
         if (obs !== e.v) begin
            n_fail++;
            $display("FAIL %s (instr %h): got %h expected %h", e.nm, ins, obs, e.v);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_ldr;
      push_fd(4'd2, 4'b0110);
      push("ldr_memadr", ev(4'd2, 4'b0000, 4'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 4'b0110));
      push("ldr_memrd",  ev(4'd3, 4'b0000, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'b0110));
      push("ldr_memwb",  ev(4'd4, 4'b0010, 4'd2, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 4'b0110));
      run_instr(32'hE5912004, 4'hF);
   endtask

   task automatic test_str(logic [31:0] ins, logic mw, string nm);
      push_fd(4'd2, 4'b0110);
      push("str_memadr", ev(4'd2, 4'b0000, 4'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 4'b0110));
      push(nm, ev(4'd5, {3'b000, mw}, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'b0110));
      run_instr(ins, 4'hF);
   endtask

   task automatic test_branch(logic [31:0] ins, logic taken, string nm);
      push_fd(4'd0, 4'b1001);
      push(nm, ev(4'd9, {taken, 3'b000}, 4'd0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 4'b1001));
      run_instr(ins, 4'h0);
   endtask

   task automatic test_subs_beq;
      push_fd(4'd1, 4'b0000);
      push("subs_execr", ev(4'd6, 4'b0000, 4'd1, 2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 4'b0000));
      push("subs_aluwb", ev(4'd8, 4'b0010, 4'd1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'b0000));
      run_instr(32'hE0511001, 4'b0110);
      test_branch(32'h0A000010, 1'b1, "beq_after_subs");
      test_branch(32'h1A000010, 1'b0, "bne_after_subs");
   endtask

   // ANDS takes NZ only (carry held from SUBS); ORR without S leaves flags alone
   task automatic test_logic_flags;
      push_fd(4'd3, 4'b0000);
      push("ands_execr", ev(4'd6, 4'b0000, 4'd3, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 4'b0000));
      push("ands_aluwb", ev(4'd8, 4'b0010, 4'd3, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'b0000));
      run_instr(32'hE0113002, 4'b1000);
      push_fd(4'd3, 4'b0000);
      push("orri_execi", ev(4'd7, 4'b0000, 4'd3, 2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 4'b0000));
      push("orri_aluwb", ev(4'd8, 4'b0010, 4'd3, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 4'b0000));
      run_instr(32'hE3823005, 4'b0000);
      test_branch(32'h2A000010, 1'b1, "bcs_carry_held");
      test_branch(32'h4A000010, 1'b1, "bmi_n_set");
      test_branch(32'h0A000010, 1'b0, "beq_z_cleared");
   endtask

   task automatic test_undef;
      push_fd(4'd0, 4'b1100);
      push_fd(4'd0, 4'b1100);
      run_instr(32'hEC000000, 4'hF);
   endtask

   task automatic test_reset_memwr;
      push_fd(4'd2, 4'b0110);
      push("rst_memadr", ev(4'd2, 4'b0000, 4'd2, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 4'b0110));
      run_instr(32'hE5812004, 4'hF);
      RESET = 1'b1;
      #1;
      n_checks++;
      if (obs !== ev(4'd5, 4'b0000, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'b0110)) begin
         n_fail++;
         $display("FAIL reset_in_memwr: got %h expected %h", obs,
                  ev(4'd5, 4'b0000, 4'd2, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 4'b0110));
      end
      @(negedge CLK);
      #1;
      n_checks++;
      if (obs !== ev(4'd0, 4'b0000, 4'd2, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 4'b0110)) begin
         n_fail++;
         $display("FAIL reset_next_fetch: got %h expected %h", obs,
                  ev(4'd0, 4'b0000, 4'd2, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 4'b0110));
      end
      RESET = 1'b0;
      test_branch(32'h2A000010, 1'b0, "bcs_flags_cleared");
      test_branch(32'h1A000010, 1'b1, "bne_flags_cleared");
   endtask

   task automatic test_bl;
      push_fd(4'd0, 4'b1001);
`ifdef CTRL_BL_EN
      push("bl_branch", ev(4'd9, 4'b1010, 4'd14, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 4'b1001));
`else
      push("bl_branch", ev(4'd9, 4'b1000, 4'd0, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 4'b1001));
`endif
      run_instr(32'hEB000010, 4'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_str(32'h05812004, 1'b0, "str_eq_memwr");
      test_ldr;
      test_str(32'hE5812004, 1'b1, "str_al_memwr");
      test_subs_beq;
      test_logic_flags;
      test_undef;
      test_reset_memwr;
      test_bl;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit instruction, 4-bit register addresses).
REQ-002 The block SHALL be clocked by CLK (in, 1); all state changes on the rising edge.
REQ-003 The block SHALL use RESET (in, 1), synchronous, active-high.
REQ-004 The block SHALL have Instr (in, 32), the latched instruction: Cond[31:28], Op[27:26], Funct[25:20], L[24], Rd[15:12].
REQ-005 The block SHALL have ALUFlags (in, 4), NZCV from the ALU, valid in execute states.
REQ-006 The block SHALL have the following write-enable outputs, 1 bit each: PCWrite, IRWrite, RegWrite (drives register file WE3) and MemWrite.
REQ-007 The block SHALL have the following datapath-select outputs:
- AdrSrc (out, 1)
- ALUSrcA (out, 1)
- ALUSrcB (out, 2)
- ResultSrc (out, 2)
- ImmSrc (out, 2)
- RegSrc (out, 2)
- ALUControl (out, 2)
REQ-008 The block SHALL have WA3 (out, 4), the register-file write address, and State (out, 4), the current state for debug.

Function
REQ-009 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-010 The FSM SHALL use these transitions:
- FETCH->DECODE.
- DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECR; Op=00 with Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->FETCH (undefined instruction, no side effects).
- MEMADR: Funct[0]=1->MEMRD, else->MEMWR.
- MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
- Codes 10-15 are illegal and SHALL go to FETCH on the next edge.
REQ-011 Select outputs SHALL be decoded per state as follows:
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=0, ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW.
- MEMWR: AdrSrc=1, MemW.
- EXECR: ALUSrcA=0, ALUSrcB=00.
- EXECI: ALUSrcA=0, ALUSrcB=01.
- ALUWB: ResultSrc=00, RegW.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Br.
- Any select not listed for a state SHALL be 0.
REQ-012 ALUControl SHALL decode Funct[4:1] in EXECR/EXECI only: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11, other->00; in every other state it SHALL be 00.
REQ-013 ImmSrc SHALL equal Op; RegSrc[0] SHALL be (Op==10); RegSrc[1] SHALL be (Op==01); all three are combinational from Instr in every state.
REQ-014 CondEx SHALL be combinational from Cond and the stored Flags, implementing ARM codes 0000-1110; code 1111 SHALL give CondEx=0.
REQ-015 RegWrite SHALL be RegW&CondEx, MemWrite SHALL be MemW&CondEx, and PCWrite SHALL be FETCH|(Br&CondEx).
REQ-016 Flags SHALL update on the edge leaving EXECR/EXECI when Funct[0]=1 and CondEx=1: NZ are always captured from ALUFlags; CV are captured only for ADD/SUB and are otherwise held.
REQ-017 WA3 SHALL equal Rd in all states unless REQ-021 applies.
REQ-018 A flag update and a CondEx evaluation in the same cycle SHALL use the pre-update Flags.

Reset
REQ-019 While RESET=1 at a rising edge: State->FETCH and Flags->0000.
REQ-020 While RESET is high, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0; a RESET asserted mid-instruction SHALL abandon that instruction with no further writes.

Configuration
REQ-021 With macro CTRL_BL_EN defined, in BRANCH with L=1 and CondEx=1 the block SHALL assert RegWrite with WA3=14 and ResultSrc=10, writing the return address to R14.
REQ-022 Without CTRL_BL_EN, BRANCH SHALL never assert RegWrite and L SHALL be ignored.

Structure
REQ-023 Package ctrl_pkg SHALL hold the state encodings, Op codes, ALUControl codes and Cond codes.
REQ-024 Sub-module cond_logic SHALL contain the Flags register, the CondEx evaluation and the flag-update logic.

Verification
REQ-025 The bench SHALL cover the following scenarios:
- LDR: Instr=0xE5912004 -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; WA3=2.
- STR with Z=0, Cond=EQ (0x05812004) -> MEMWR with MemWrite=0; no register write.
- SUBS R1,R1,R1 with ALUFlags=0110 in EXECR -> Flags=0110 after the edge; a following BEQ has PCWrite=1 in BRANCH.
- Op=11 instruction -> FETCH,DECODE,FETCH with no write enables.
- RESET asserted in MEMWR -> MemWrite=0 that cycle; next state FETCH; Flags=0000.
- BL with CTRL_BL_EN: 0xEB000010 -> RegWrite=1, WA3=14 in BRANCH; without the macro -> RegWrite=0.
